// File: rtl/reduce_engine.sv
// Serial reduction engine: folds a WIDTH-bit operand CHUNK bits per cycle
// into one AND/OR/XOR/XNOR bit plus its population count.
module reduce_engine #(
   parameter  int WIDTH = 16,
   parameter  int CHUNK = 4,
   localparam int NCYC  = WIDTH / CHUNK,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_result,
   output logic [CW-1:0]    out_count
);

   localparam int CNTW = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam logic [CNTW-1:0] LAST = CNTW'(NCYC - 1);

   generate
      if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
         $error("reduce_engine: CHUNK must divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  op_q, op_d;
   logic [1:0]        mode_q, mode_d;
   logic              acc_q, acc_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]     pc_q, pc_d;
   logic              res_q, res_d;
   logic [CW-1:0]     ocnt_q, ocnt_d;

   logic [CHUNK-1:0]  chunk;
   logic [WIDTH-1:0]  op_shift;
   logic              acc_nx;
   logic [CW-1:0]     pc_nx;

   function automatic logic [CW-1:0] popc(input logic [CHUNK-1:0] v);
      logic [CW-1:0] s;
      s = '0;
      for (int i = 0; i < CHUNK; i++) begin
         s = s + CW'(v[i]);
      end
      return s;
   endfunction

   // Operand shifts down so the active chunk always sits in the low bits
   assign chunk = op_q[CHUNK-1:0];

   generate
      if (NCYC > 1) begin : g_shift
         assign op_shift = {{CHUNK{1'b0}}, op_q[WIDTH-1:CHUNK]};
      end else begin : g_noshift
         assign op_shift = '0;
      end
   endgenerate

   always_comb begin
      acc_nx = acc_q;
      unique case (mode_q)
         2'b00:   acc_nx = acc_q & (&chunk);
         2'b01:   acc_nx = acc_q | (|chunk);
         default: acc_nx = acc_q ^ (^chunk);
      endcase
      pc_nx = pc_q + popc(chunk);
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      res_d   = res_q;
      ocnt_d  = ocnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = in_data;
               mode_d  = in_mode;
               cnt_d   = '0;
               pc_d    = '0;
               acc_d   = (in_mode == 2'b00);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            op_d  = op_shift;
            acc_d = acc_nx;
            pc_d  = pc_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               res_d   = (mode_q == 2'b11) ? ~acc_nx : acc_nx;
               ocnt_d  = pc_nx;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         mode_q  <= '0;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         pc_q    <= '0;
         res_q   <= 1'b0;
         ocnt_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         res_q   <= res_d;
         ocnt_q  <= ocnt_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign out_result = res_q;
   assign out_count  = ocnt_q;

endmodule

// File: tb/tb_reduce_engine.sv
// Directed and random checks of reduce_engine at 16/4, 3/1 and 8/8.
module tb_reduce_engine;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        a_iv, a_rdy, a_ov, a_or, a_res;
   logic [15:0] a_din;
   logic [1:0]  a_md;
   logic [4:0]  a_cnt;

   logic        b_iv, b_rdy, b_ov, b_or, b_res;
   logic [2:0]  b_din;
   logic [1:0]  b_md;
   logic [1:0]  b_cnt;

   logic        c_iv, c_rdy, c_ov, c_or, c_res;
   logic [7:0]  c_din;
   logic [1:0]  c_md;
   logic [3:0]  c_cnt;

   reduce_engine #(.WIDTH(16), .CHUNK(4)) u_a (
      .clk(clk), .rst(rst),
      .in_valid(a_iv), .in_ready(a_rdy), .in_data(a_din), .in_mode(a_md),
      .out_valid(a_ov), .out_ready(a_or), .out_result(a_res), .out_count(a_cnt)
   );

   reduce_engine #(.WIDTH(3), .CHUNK(1)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(b_iv), .in_ready(b_rdy), .in_data(b_din), .in_mode(b_md),
      .out_valid(b_ov), .out_ready(b_or), .out_result(b_res), .out_count(b_cnt)
   );

   reduce_engine #(.WIDTH(8), .CHUNK(8)) u_c (
      .clk(clk), .rst(rst),
      .in_valid(c_iv), .in_ready(c_rdy), .in_data(c_din), .in_mode(c_md),
      .out_valid(c_ov), .out_ready(c_or), .out_result(c_res), .out_count(c_cnt)
   );

   int nvec = 0;
   int errs = 0;

   typedef struct {
      int          w;
      logic [15:0] d;
      logic [1:0]  m;
      logic        r;
      logic [4:0]  c;
      int          lat;
      string       nm;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic rdy(input int w);
      case (w)
         0:       return a_rdy;
         1:       return b_rdy;
         default: return c_rdy;
      endcase
   endfunction

   function automatic logic vld(input int w);
      case (w)
         0:       return a_ov;
         1:       return b_ov;
         default: return c_ov;
      endcase
   endfunction

   function automatic logic res(input int w);
      case (w)
         0:       return a_res;
         1:       return b_res;
         default: return c_res;
      endcase
   endfunction

   function automatic logic [4:0] cnt(input int w);
      case (w)
         0:       return a_cnt;
         1:       return {3'b000, b_cnt};
         default: return {1'b0, c_cnt};
      endcase
   endfunction

   task automatic drive(input int w, input logic v, input logic [15:0] d,
                        input logic [1:0] m);
      case (w)
         0: begin a_iv = v; a_din = d; a_md = m; end
         1: begin b_iv = v; b_din = d[2:0]; b_md = m; end
         default: begin c_iv = v; c_din = d[7:0]; c_md = m; end
      endcase
   endtask

   // Wait for in_ready, offer one operand, scramble the inputs afterwards
   // and check latency, result and count.
   task automatic run(input int w, input logic [15:0] d, input logic [1:0] m,
                      input logic r, input logic [4:0] c, input int elat,
                      input string nm);
      int n;
      n = 0;
      while (!rdy(w) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, " in_ready"}, 32'(rdy(w)), 32'd1);
      drive(w, 1'b1, d, m);
      @(posedge clk); #1;
      drive(w, 1'b0, ~d, ~m);
      n = 0;
      while (!vld(w) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, " latency"}, 32'(n), 32'(elat));
      chk({nm, " result"}, 32'(res(w)), 32'(r));
      chk({nm, " count"}, 32'(cnt(w)), 32'(c));
   endtask

   function automatic void model(input int width, input logic [15:0] d,
                                 input logic [1:0] m, output logic r,
                                 output logic [4:0] c);
      logic [15:0] x;
      x = d & ((16'h1 << width) - 16'h1);
      if (width == 16) x = d;
      c = 5'($countones(x));
      case (m)
         2'b00:   r = (c == 5'(width));
         2'b01:   r = (c != 0);
         2'b10:   r = c[0];
         default: r = ~c[0];
      endcase
   endfunction

   initial begin
      int          n;
      logic        er;
      logic [4:0]  ec;
      logic [15:0] rd;
      logic [1:0]  rm;
      int          ws[3];
      int          ls[3];

      ws = '{16, 3, 8};
      ls = '{4, 3, 1};

      a_iv = 0; a_din = '0; a_md = '0; a_or = 1;
      b_iv = 0; b_din = '0; b_md = '0; b_or = 1;
      c_iv = 0; c_din = '0; c_md = '0; c_or = 1;

      tbl.push_back('{0, 16'hFFFF, 2'b00, 1'b1, 5'd16, 4, "and_ffff"});
      tbl.push_back('{0, 16'hFFEF, 2'b00, 1'b0, 5'd15, 4, "and_ffef"});
      tbl.push_back('{0, 16'h0000, 2'b01, 1'b0, 5'd0,  4, "or_0000"});
      tbl.push_back('{0, 16'h8000, 2'b01, 1'b1, 5'd1,  4, "or_8000"});
      tbl.push_back('{0, 16'h0007, 2'b10, 1'b1, 5'd3,  4, "xor_0007"});
      tbl.push_back('{0, 16'h0007, 2'b11, 1'b0, 5'd3,  4, "xnor_0007"});
      tbl.push_back('{0, 16'hA5A5, 2'b10, 1'b0, 5'd8,  4, "xor_a5a5"});
      tbl.push_back('{0, 16'hA5A5, 2'b11, 1'b1, 5'd8,  4, "xnor_a5a5"});
      tbl.push_back('{1, 16'h0007, 2'b00, 1'b1, 5'd3,  3, "w3_and_111"});
      tbl.push_back('{1, 16'h0002, 2'b00, 1'b0, 5'd1,  3, "w3_and_010"});
      tbl.push_back('{1, 16'h0005, 2'b10, 1'b0, 5'd2,  3, "w3_xor_101"});
      tbl.push_back('{2, 16'h0081, 2'b10, 1'b0, 5'd2,  1, "w8_xor_81"});
      tbl.push_back('{2, 16'h00FF, 2'b00, 1'b1, 5'd8,  1, "w8_and_ff"});
      tbl.push_back('{2, 16'h0000, 2'b11, 1'b1, 5'd0,  1, "w8_xnor_00"});

      // Asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1;
      for (int w = 0; w < 3; w++) begin
         chk($sformatf("reset%0d out_valid", w), 32'(vld(w)), 32'd0);
         chk($sformatf("reset%0d out_result", w), 32'(res(w)), 32'd0);
         chk($sformatf("reset%0d out_count", w), 32'(cnt(w)), 32'd0);
         chk($sformatf("reset%0d in_ready", w), 32'(rdy(w)), 32'd1);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      foreach (tbl[i]) begin
         run(tbl[i].w, tbl[i].d, tbl[i].m, tbl[i].r, tbl[i].c, tbl[i].lat,
             tbl[i].nm);
      end

      // Backpressure: hold out_ready low, offer a competing operand
      a_or = 1'b0;
      run(0, 16'hFFFF, 2'b00, 1'b1, 5'd16, 4, "bp_job");
      drive(0, 1'b1, 16'h0000, 2'b01);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp out_valid", 32'(a_ov), 32'd1);
         chk("bp in_ready", 32'(a_rdy), 32'd0);
         chk("bp result", 32'(a_res), 32'd1);
         chk("bp count", 32'(a_cnt), 32'd16);
      end
      drive(0, 1'b0, 16'h0000, 2'b01);
      a_or = 1'b1;
      @(posedge clk); #1;
      chk("bp release in_ready", 32'(a_rdy), 32'd1);
      chk("bp release out_valid", 32'(a_ov), 32'd0);
      chk("bp held result", 32'(a_res), 32'd1);
      chk("bp held count", 32'(a_cnt), 32'd16);
      run(0, 16'h00F3, 2'b10, 1'b0, 5'd6, 4, "bp_next");

      // Reset during the second BUSY cycle discards the job
      @(posedge clk); #1;
      drive(0, 1'b1, 16'hFFFF, 2'b00);
      @(posedge clk); #1;
      drive(0, 1'b0, 16'h0000, 2'b00);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst in_ready", 32'(a_rdy), 32'd1);
      chk("midrst out_valid", 32'(a_ov), 32'd0);
      #2 rst = 1'b0;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (a_ov) n++;
      end
      chk("midrst no output", 32'(n), 32'd0);
      run(0, 16'h00F0, 2'b01, 1'b1, 5'd4, 4, "after_rst");

      // Random operands against a reference reduction
      for (int k = 0; k < 30; k++) begin
         int w;
         w  = k % 3;
         rd = 16'($urandom);
         rm = 2'($urandom_range(3));
         model(ws[w], rd, rm, er, ec);
         run(w, rd, rm, er, ec, ls[w], $sformatf("rand%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

endmodule
